// File: rtl/coeff_write_sequencer.sv
// Coefficient write sequencer: streams N words from a synchronous source memory onto the coefficient write bus.
// Optional running checksum output enabled by defining COEFF_WRITE_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | waiting for i_start; captures clamped word count
// FETCH  | source latches address 0; next read address issued
// STREAM | one write per enabled cycle, read address one ahead
// DONE   | single write_done pulse, then back to IDLE
module coeff_write_sequencer #(
    parameter int NUM_COEFFS = 48,
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_enable,
    input  logic              i_start,
    input  logic [6:0]        i_count,
    output logic [ADDR_W-1:0] o_src_addr,
    output logic              o_src_en,
    input  logic [DATA_W-1:0] i_src_data,
    output logic              o_write_enable,
    output logic              o_write_done,
    output logic [ADDR_W-1:0] o_write_address,
    output logic [DATA_W-1:0] o_coeffs_in,
    output logic              o_busy
`ifdef COEFF_WRITE_CHECKSUM_EN
    ,
    output logic [15:0]       o_checksum
`endif
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [6:0] MAX_N = 7'(NUM_COEFFS);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   n_words, n_words_nxt;
    logic [CNT_W-1:0]   k, k_nxt;
    logic [6:0]         n_clamp;
    logic [ADDR_W-1:0]  src_addr_nxt;
    logic               src_en_nxt;
    logic               write_enable_nxt;
    logic               write_done_nxt;
    logic [ADDR_W-1:0]  write_address_nxt;
    logic [DATA_W-1:0]  coeffs_nxt;
    logic               busy_nxt;
`ifdef COEFF_WRITE_CHECKSUM_EN
    logic [15:0]        checksum_nxt;
`endif

    assign n_clamp = (i_count > MAX_N) ? MAX_N : i_count;

    always_comb begin
        state_nxt         = state;
        n_words_nxt       = n_words;
        k_nxt             = k;
        src_addr_nxt      = o_src_addr;
        src_en_nxt        = o_src_en;
        write_enable_nxt  = 1'b0;
        write_done_nxt    = 1'b0;
        write_address_nxt = o_write_address;
        coeffs_nxt        = o_coeffs_in;
`ifdef COEFF_WRITE_CHECKSUM_EN
        checksum_nxt      = o_checksum;
`endif
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    n_words_nxt = CNT_W'(n_clamp);
`ifdef COEFF_WRITE_CHECKSUM_EN
                    checksum_nxt = '0;
`endif
                    if (n_clamp == 7'd0) begin
                        state_nxt = S_DONE;
                    end else begin
                        src_addr_nxt = '0;
                        src_en_nxt   = 1'b1;
                        state_nxt    = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (n_words > CNT_W'(1)) begin
                    src_addr_nxt = ADDR_W'(1);
                end else begin
                    src_en_nxt = 1'b0;
                end
                k_nxt     = '0;
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                write_enable_nxt  = 1'b1;
                write_address_nxt = k[ADDR_W-1:0];
                coeffs_nxt        = i_src_data;
`ifdef COEFF_WRITE_CHECKSUM_EN
                checksum_nxt      = o_checksum + 16'(i_src_data);
`endif
                k_nxt             = k + CNT_W'(1);
                // the source latches k+1 on this edge, so the next address to issue is k+2
                if ((k + CNT_W'(2)) < n_words) begin
                    src_addr_nxt = ADDR_W'(k + CNT_W'(2));
                end else begin
                    src_en_nxt = 1'b0;
                end
                if (k == n_words - CNT_W'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                write_done_nxt = 1'b1;
                state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= S_IDLE;
            n_words         <= '0;
            k               <= '0;
            o_src_addr      <= '0;
            o_src_en        <= 1'b0;
            o_write_enable  <= 1'b0;
            o_write_done    <= 1'b0;
            o_write_address <= '0;
            o_coeffs_in     <= '0;
            o_busy          <= 1'b0;
`ifdef COEFF_WRITE_CHECKSUM_EN
            o_checksum      <= '0;
`endif
        end else if (clk_enable) begin
            state           <= state_nxt;
            n_words         <= n_words_nxt;
            k               <= k_nxt;
            o_src_addr      <= src_addr_nxt;
            o_src_en        <= src_en_nxt;
            o_write_enable  <= write_enable_nxt;
            o_write_done    <= write_done_nxt;
            o_write_address <= write_address_nxt;
            o_coeffs_in     <= coeffs_nxt;
            o_busy          <= busy_nxt;
`ifdef COEFF_WRITE_CHECKSUM_EN
            o_checksum      <= checksum_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_coeff_write_sequencer.sv
// Self-checking bench for coeff_write_sequencer: random source data and gating against a transaction-level model.
module tb_coeff_write_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_enable = 1'b0;
    logic        i_start = 1'b0;
    logic [6:0]  i_count = '0;
    logic [5:0]  o_src_addr;
    logic        o_src_en;
    logic [15:0] i_src_data = '0;
    logic        o_write_enable;
    logic        o_write_done;
    logic [5:0]  o_write_address;
    logic [15:0] o_coeffs_in;
    logic        o_busy;
`ifdef COEFF_WRITE_CHECKSUM_EN
    logic [15:0] o_checksum;
    logic [15:0] cs_at_done;
`endif

    int checks = 0;
    int failures = 0;

    logic [15:0] mem [64];
    int wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int done_cnt, first_idx, done_idx, busy_low_idx;
    bit timed_out;

    coeff_write_sequencer dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .i_start(i_start), .i_count(i_count),
        .o_src_addr(o_src_addr), .o_src_en(o_src_en), .i_src_data(i_src_data),
        .o_write_enable(o_write_enable), .o_write_done(o_write_done),
        .o_write_address(o_write_address), .o_coeffs_in(o_coeffs_in), .o_busy(o_busy)
`ifdef COEFF_WRITE_CHECKSUM_EN
        , .o_checksum(o_checksum)
`endif
    );

    always #5 clk = ~clk;

    // synchronous source memory, advances with the same qualifier as the DUT
    always @(posedge clk) if (clk_enable && o_src_en) i_src_data <= mem[o_src_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    endtask

    // gate: 0 always enabled, 1 pattern 1,0,0,1, 2 random
    task automatic run_load(input int cnt, input int gate, input int restart_at);
        int idx;
        bit en, finished;
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0; first_idx = -1; done_idx = -1; busy_low_idx = -1;
        timed_out = 0; finished = 0; idx = 0;
        clk_enable = 1'b1;
        i_count = 7'(cnt);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int cyc = 0; cyc < 1000 && !finished; cyc++) begin
            case (gate)
                1: clk_enable = (cyc % 4 == 0) || (cyc % 4 == 3);
                2: clk_enable = 1'($urandom_range(0, 1));
                default: clk_enable = 1'b1;
            endcase
            en = clk_enable;
            step();
            i_start = 1'b0;
            if (en) begin
                idx++;
                if (o_write_enable) begin
                    if (first_idx < 0) first_idx = idx;
                    wr_addr_q.push_back(int'(o_write_address));
                    wr_data_q.push_back(o_coeffs_in);
                    if (restart_at >= 0 && int'(o_write_address) == restart_at) i_start = 1'b1;
                end
                if (o_write_done) begin
                    done_cnt++;
                    done_idx = idx;
`ifdef COEFF_WRITE_CHECKSUM_EN
                    cs_at_done = o_checksum;
`endif
                end
                if (!o_busy && busy_low_idx < 0) busy_low_idx = idx;
                if (done_idx >= 0 && idx >= done_idx + 3) finished = 1;
            end
        end
        if (!finished) timed_out = 1;
        clk_enable = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; clk_enable = 1'b0;
        step(); step();
        checks++;
        if ({o_src_addr, o_src_en, o_write_enable, o_write_done, o_write_address, o_coeffs_in, o_busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got addr=%0d en=%0d we=%0d wd=%0d wa=%0d d=%0d busy=%0d, want all 0",
                     o_src_addr, o_src_en, o_write_enable, o_write_done, o_write_address, o_coeffs_in, o_busy);
        end
`ifdef COEFF_WRITE_CHECKSUM_EN
        checks++;
        if (o_checksum !== 16'h0) begin
            failures++;
            $display("FAIL reset_checksum: got %h want 0000", o_checksum);
        end
`endif
        rst = 1'b1; clk_enable = 1'b1;
        step();
    endtask

    task automatic test_full_load();
        int exp_data;
        for (int i = 0; i < 64; i++) mem[i] = 16'(i * 3 - 70);
        run_load(48, 0, -1);
        checks++;
        if (timed_out || wr_addr_q.size() != 48) begin
            failures++;
            $display("FAIL full_count: got %0d writes (timeout=%0d), want 48", wr_addr_q.size(), timed_out);
        end
        for (int i = 0; i < wr_addr_q.size() && i < 48; i++) begin
            exp_data = i * 3 - 70;
            checks++;
            if (wr_addr_q[i] !== i || wr_data_q[i] !== 16'(exp_data)) begin
                failures++;
                $display("FAIL full_write%0d: got addr=%0d data=%0d, want addr=%0d data=%0d",
                         i, wr_addr_q[i], $signed(wr_data_q[i]), i, exp_data);
            end
        end
        checks++;
        if (first_idx != 2 || done_cnt != 1 || done_idx != 50 || busy_low_idx != 50) begin
            failures++;
            $display("FAIL full_timing: got first=%0d dones=%0d done_at=%0d busy_low_at=%0d, want 2 1 50 50",
                     first_idx, done_cnt, done_idx, busy_low_idx);
        end
    endtask

    task automatic test_gating();
        fill_random();
        run_load(5, 1, -1);
        checks++;
        if (timed_out || wr_addr_q.size() != 5 || done_cnt != 1) begin
            failures++;
            $display("FAIL gating_count: got %0d writes %0d dones, want 5 1", wr_addr_q.size(), done_cnt);
        end
        for (int i = 0; i < wr_addr_q.size() && i < 5; i++) begin
            checks++;
            if (wr_addr_q[i] !== i || wr_data_q[i] !== mem[i]) begin
                failures++;
                $display("FAIL gating_write%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                         i, wr_addr_q[i], wr_data_q[i], i, mem[i]);
            end
        end
        checks++;
        if (first_idx != 2 || done_idx != 7) begin
            failures++;
            $display("FAIL gating_timing: got first=%0d done_at=%0d, want 2 7", first_idx, done_idx);
        end
    endtask

    task automatic test_hold_and_reset();
        logic [43:0] snap, now;
        bit found = 0;
        int bad = 0;
        fill_random();
        clk_enable = 1'b1; i_count = 7'd20; i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            step();
            if (o_write_enable && o_write_address == 6'd10) found = 1;
        end
        checks++;
        if (!found || o_coeffs_in !== mem[10]) begin
            failures++;
            $display("FAIL reach_k10: got found=%0d data=%h, want 1 %h", found, o_coeffs_in, mem[10]);
        end
        snap = {o_src_addr, o_src_en, o_write_enable, o_write_done, o_write_address, o_coeffs_in, o_busy, 7'd0};
        clk_enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            now = {o_src_addr, o_src_en, o_write_enable, o_write_done, o_write_address, o_coeffs_in, o_busy, 7'd0};
            checks++;
            if (now !== snap) begin
                failures++;
                $display("FAIL hold_cycle%0d: got %h want %h", c, now, snap);
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if ({o_src_addr, o_src_en, o_write_enable, o_write_done, o_write_address, o_coeffs_in, o_busy} !== '0) begin
            failures++;
            $display("FAIL midstream_reset: got we=%0d wa=%0d d=%h busy=%0d src_en=%0d, want all 0",
                     o_write_enable, o_write_address, o_coeffs_in, o_busy, o_src_en);
        end
        rst = 1'b1; clk_enable = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            if (o_write_done || o_write_enable || o_busy) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL abort_quiet: got %0d active cycles after reset, want 0", bad);
        end
    endtask

    task automatic test_edge_counts();
        int cnts[3] = '{0, 1, 100};
        int exp_n, exp_done;
        fill_random();
        foreach (cnts[j]) begin
            run_load(cnts[j], 0, -1);
            exp_n = (cnts[j] > 48) ? 48 : cnts[j];
            exp_done = (exp_n == 0) ? 1 : exp_n + 2;
            checks++;
            if (timed_out || wr_addr_q.size() != exp_n || done_cnt != 1 || done_idx != exp_done) begin
                failures++;
                $display("FAIL edge_cnt%0d: got writes=%0d dones=%0d done_at=%0d, want %0d 1 %0d",
                         cnts[j], wr_addr_q.size(), done_cnt, done_idx, exp_n, exp_done);
            end
            for (int i = 0; i < wr_addr_q.size() && i < exp_n; i++) begin
                checks++;
                if (wr_addr_q[i] !== i || wr_data_q[i] !== mem[i]) begin
                    failures++;
                    $display("FAIL edge_cnt%0d_write%0d: got addr=%0d data=%h, want %0d %h",
                             cnts[j], i, wr_addr_q[i], wr_data_q[i], i, mem[i]);
                end
            end
        end
    endtask

    task automatic test_start_while_busy();
        fill_random();
        run_load(8, 0, 3);
        checks++;
        if (timed_out || wr_addr_q.size() != 8 || done_cnt != 1) begin
            failures++;
            $display("FAIL busy_start: got writes=%0d dones=%0d, want 8 1", wr_addr_q.size(), done_cnt);
        end
        run_load(4, 0, -1);
        checks++;
        if (wr_addr_q.size() != 4 || wr_addr_q[0] !== 0 || wr_data_q[0] !== mem[0] || first_idx != 2) begin
            failures++;
            $display("FAIL restart_idle: got writes=%0d first_addr=%0d first_at=%0d, want 4 0 2",
                     wr_addr_q.size(), (wr_addr_q.size() > 0) ? wr_addr_q[0] : -1, first_idx);
        end
    endtask

    task automatic test_random_loads();
        int cnt, exp_n, bad;
`ifdef COEFF_WRITE_CHECKSUM_EN
        logic [15:0] exp_cs;
`endif
        for (int t = 0; t < 6; t++) begin
            fill_random();
            cnt = $urandom_range(0, 80);
            exp_n = (cnt > 48) ? 48 : cnt;
            run_load(cnt, 2, -1);
            bad = 0;
            for (int i = 0; i < wr_addr_q.size() && i < exp_n; i++)
                if (wr_addr_q[i] !== i || wr_data_q[i] !== mem[i]) bad++;
            checks++;
            if (timed_out || wr_addr_q.size() != exp_n || done_cnt != 1 || bad != 0) begin
                failures++;
                $display("FAIL random%0d_cnt%0d: got writes=%0d dones=%0d bad=%0d, want %0d 1 0",
                         t, cnt, wr_addr_q.size(), done_cnt, bad, exp_n);
            end
`ifdef COEFF_WRITE_CHECKSUM_EN
            exp_cs = '0;
            for (int i = 0; i < exp_n; i++) exp_cs = exp_cs + mem[i];
            checks++;
            if (cs_at_done !== exp_cs) begin
                failures++;
                $display("FAIL random%0d_checksum: got %h want %h", t, cs_at_done, exp_cs);
            end
`endif
        end
    endtask

`ifdef COEFF_WRITE_CHECKSUM_EN
    task automatic test_checksum();
        mem[0] = 16'h7FFF; mem[1] = 16'h0002; mem[2] = 16'hFFFF;
        run_load(3, 0, -1);
        checks++;
        if (cs_at_done !== 16'h8000 || o_checksum !== 16'h8000) begin
            failures++;
            $display("FAIL checksum: got at_done=%h after=%h, want 8000", cs_at_done, o_checksum);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_gating();
        test_hold_and_reset();
        test_edge_counts();
        test_start_while_busy();
        test_random_loads();
`ifdef COEFF_WRITE_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coeff_write_sequencer.md
Name: coeff_write_sequencer

Overview:
- Initiator side of the coefficient-write interface (write_enable / write_done / write_address / coeffs_in) that feeds the equalizer's coefficient bank through its input pipeline register.
- On a start request, reads N signed 16-bit coefficients from a synchronous source memory and streams them as one write per enabled cycle, with addresses 0..N-1.
- Closes each stream with a single-cycle write_done pulse.
- Sits between the host or preset table and the filter-bank coefficient path.

Parameters:
- NUM_COEFFS, 48, maximum words per load (8 bands x 6 words); must be in the range 1..64.
- ADDR_W, 6, address width of the source memory and of the write bus.
- DATA_W, 16, coefficient width (signed).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- clk_enable  in  1  global advance qualifier; when 0, all state and outputs hold.
- i_start  in  1  load request; sampled only in IDLE with clk_enable=1.
- i_count  in  7  number of words to write; 0 means no words; values above NUM_COEFFS are clamped to NUM_COEFFS.
- o_src_addr  out  ADDR_W  source memory read address.
- o_src_en  out  1  source memory read enable.
- i_src_data  in  DATA_W  source read data, valid one enabled cycle after the address is presented.
- o_write_enable  out  1  coefficient write strobe.
- o_write_done  out  1  end-of-load pulse.
- o_write_address  out  ADDR_W  write address.
- o_coeffs_in  out  DATA_W  signed coefficient value.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: rst=0 at a clk edge forces state=IDLE and drives every output to 0, regardless of clk_enable.
  - Reset mid-stream aborts the load; no write_done is issued.
- All registers update only on edges where clk_enable=1. When clk_enable=0, every output holds its previous value, including o_write_enable and o_write_done.
- All outputs are registered.
- States:
  - IDLE: o_busy=0.
    - If i_start=1, capture n = min(i_count, NUM_COEFFS).
    - If n=0, go to DONE.
    - Otherwise set o_src_addr<=0 and o_src_en<=1, then go to FETCH.
  - FETCH: one cycle; the source latches address 0.
    - Set o_src_addr<=1 if n>1; otherwise set o_src_en<=0.
    - Go to STREAM.
  - STREAM: each enabled edge registers o_write_enable<=1, o_write_address<=k, o_coeffs_in<=i_src_data, where k counts 0..n-1.
    - The read address stays one ahead of k. o_src_en drops after address n-1 has been issued.
    - After the edge that writes k=n-1, go to DONE.
  - DONE: registers o_write_enable<=0 and o_write_done<=1 for exactly one enabled cycle, then returns to IDLE with o_write_done<=0.
- Latency:
  - The first write is visible after the 2nd enabled edge following the edge that sampled i_start.
  - Writes are back-to-back, one per enabled cycle.
  - write_done appears in the enabled cycle after the last write.
  - Total time from the start edge to the end of write_done is n+2 enabled cycles.
- o_write_address and o_coeffs_in hold their last written values when o_write_enable=0.
- o_src_addr holds its last value when o_src_en=0.
- i_start while o_busy=1 is ignored; no queuing.
- i_start held high through DONE is accepted again only once the block is back in IDLE (it is re-sampled there).
- n=64 with ADDR_W=6: addresses 0..63. The internal counter is ADDR_W+1 bits so the address does not wrap before the terminal compare.
- Data is passed through unmodified; there is no sign or width conversion.

Optional Feature:
- Macro: COEFF_WRITE_CHECKSUM_EN.
- When defined, adds port o_checksum (out, 16 bits): a mod-2^16 sum of every o_coeffs_in written during the current load.
  - Cleared when a start is accepted.
  - Updated on each write.
  - Stable and valid while o_write_done=1; holds until the next accepted start.
  - Reset value 0.
- When not defined, the port and its accumulator are absent. All other behaviour is identical.

Test Plan:
- Reset/hold: assert rst=0 mid-stream at k=10 -> all outputs 0 on the next edge, no write_done; with clk_enable=0 and rst=1, outputs stay frozen for 5 cycles.
- Full load: i_count=48 with src[k]=k*3-70 -> 48 consecutive writes at addresses 0..47 with data -70,-67,..., 71, write_done one cycle after address 47, o_busy low 50 cycles after the start edge.
- Gating: toggle clk_enable 1,0,0,1 throughout an n=5 load -> exactly 5 writes and 1 done counted on enabled edges; no address is skipped or duplicated.
- Edge counts: i_count=0 -> no writes and write_done on the 1st enabled edge after start; i_count=1 -> a single write to address 0; i_count=100 -> clamped to 48 writes.
- Start during busy: pulse i_start at k=3 of an n=8 load -> still 8 writes and one done; a start re-asserted in IDLE after done begins a new load at address 0.
- Checksum (with COEFF_WRITE_CHECKSUM_EN): src = {0x7FFF, 0x0002, 0xFFFF}, n=3 -> o_checksum=0x8000 while write_done=1.
